// File: rtl/uart_serial_tx_if.sv
// ---------------------------------------------------------------------------
// uart_serial_tx_if
// Byte-write handshake between the upstream frame builder (master) and the
// UART transmitter (slave).
//   tx_en    : single-cycle byte write strobe (master -> slave)
//   tx_data  : byte to send, valid while tx_en is high (master -> slave)
//   tx_ready : at least two FIFO entries are free (slave -> master)
// ---------------------------------------------------------------------------
interface uart_serial_tx_if;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (
        output tx_en,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_en,
        input  tx_data,
        output tx_ready
    );
endinterface

// File: rtl/uart_serial_tx.sv
// ---------------------------------------------------------------------------
// uart_serial_tx
// Byte FIFO feeding an 8N1-style UART serialiser (8 data bits LSB first,
// optional even parity, 1 or 2 stop bits). Frames are sent back-to-back
// while the FIFO holds data.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> start, 8 data, even parity, stop
//   undefined -> start, 8 data, stop (no PARITY state)
//
// Parameters:
//   CLK_DIV    : clk cycles per UART bit (>= 4)
//   STOP_BITS  : 1 or 2
//   FIFO_DEPTH : byte FIFO entries, power of two, >= 4
//
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   tx_if      : slave side of the byte write handshake (tx_en/tx_data/tx_ready)
//   err_clr_i  : clears the sticky overflow flag
//   uart_txd_o : registered serial line, idle high
//   busy_o     : FSM active or FIFO not empty
//   ovf_err_o  : sticky flag, a write was dropped on a full FIFO
// ---------------------------------------------------------------------------
module uart_serial_tx #(
    parameter int CLK_DIV    = 868,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_serial_tx_if.slave tx_if,
    input  logic            err_clr_i,
    output logic            uart_txd_o,
    output logic            busy_o,
    output logic            ovf_err_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [NW-1:0] DEPTH_N   = NW'(FIFO_DEPTH);
    localparam logic [NW-1:0] READY_MAX = NW'(FIFO_DEPTH - 2);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   bitCnt_q, bitCnt_d;
    logic [2:0]      bitIdx_q, bitIdx_d;
    logic            stopCnt_q, stopCnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
    logic            parity_q, parity_d;
`endif

    logic [7:0]      fifoMem_q [FIFO_DEPTH];
    logic [PW-1:0]   wrPtr_q, wrPtr_d;
    logic [PW-1:0]   rdPtr_q, rdPtr_d;
    logic [NW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;

    logic            bitEnd;
    logic            fifoEmpty;
    logic            fifoFull;
    logic            pop;
    logic            push;
    logic            drop;
    logic [7:0]      headByte;

    assign bitEnd    = (bitCnt_q == BIT_LAST);
    assign fifoEmpty = (count_q == '0);
    assign fifoFull  = (count_q == DEPTH_N);
    assign headByte  = fifoMem_q[rdPtr_q];

    // Serialiser next-state logic. The line value is decoded from the current
    // state and registered, so the wire lags the state by one clock; every bit
    // still lasts exactly CLK_DIV cycles.
    always_comb begin
        state_d   = state_q;
        bitCnt_d  = bitEnd ? '0 : bitCnt_q + 1'b1;
        bitIdx_d  = bitIdx_q;
        stopCnt_d = stopCnt_q;
        shift_d   = shift_q;
        txd_d     = 1'b1;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                bitCnt_d = '0;
                if (!fifoEmpty) begin
                    pop      = 1'b1;
                    shift_d  = headByte;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^headByte;
`endif
                    state_d  = START;
                end
            end
            START: begin
                txd_d = 1'b0;
                if (bitEnd) begin
                    bitIdx_d = 3'd0;
                    state_d  = DATA;
                end
            end
            DATA: begin
                txd_d = shift_q[0];
                if (bitEnd) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bitIdx_q == 3'd7) begin
                        stopCnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                txd_d = parity_q;
                if (bitEnd) begin
                    stopCnt_d = 1'b0;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                txd_d = 1'b1;
                if (bitEnd) begin
                    if (stopCnt_q == STOP_LAST) begin
                        // Chain straight into the next frame when data is waiting.
                        if (!fifoEmpty) begin
                            pop      = 1'b1;
                            shift_d  = headByte;
`ifdef UART_TX_PARITY_EN
                            parity_d = ^headByte;
`endif
                            state_d  = START;
                        end else begin
                            state_d  = IDLE;
                        end
                    end else begin
                        stopCnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                bitCnt_d = '0;
            end
        endcase
    end

    // FIFO bookkeeping. A pop frees a slot in the same cycle, so a write at
    // full is accepted when it coincides with a pop.
    always_comb begin
        push    = tx_if.tx_en && (!fifoFull || pop);
        drop    = tx_if.tx_en && fifoFull && !pop;
        wrPtr_d = push ? wrPtr_q + 1'b1 : wrPtr_q;
        rdPtr_d = pop  ? rdPtr_q + 1'b1 : rdPtr_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Setting wins over clearing when both happen together.
        ovf_d = drop ? 1'b1 : (err_clr_i ? 1'b0 : ovf_q);
    end

    // All control state; reset aborts any frame and empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bitCnt_q  <= '0;
            bitIdx_q  <= 3'd0;
            stopCnt_q <= 1'b0;
            shift_q   <= 8'h00;
            txd_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitCnt_q  <= bitCnt_d;
            bitIdx_q  <= bitIdx_d;
            stopCnt_q <= stopCnt_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    // FIFO storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= tx_if.tx_data;
        end
    end

    assign tx_if.tx_ready = (count_q <= READY_MAX);
    assign busy_o         = (state_q != IDLE) || !fifoEmpty;
    assign uart_txd_o     = txd_q;
    assign ovf_err_o      = ovf_q;

endmodule

// File: tb/tb_uart_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_serial_tx
// Self-checking bench for uart_serial_tx. Two instances: dut1 with one stop
// bit and dut2 with two stop bits, both CLK_DIV=4, FIFO_DEPTH=4. Compiles
// with or without UART_TX_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_uart_serial_tx;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FL1 = 10 + PAR_BITS;
    localparam int FL2 = 11 + PAR_BITS;

    typedef struct {
        logic [7:0] data;
        logic [9:0] expLine;
        logic       expParity;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic errClr1, errClr2;
    logic txd1, busy1, ovf1;
    logic txd2, busy2, ovf2;

    int assertCount = 0;
    int failCount   = 0;

    logic       rec [0:511];
    int         recLen = 0;
    logic [7:0] expBytes [0:15];

    uart_serial_tx_if if1 ();
    uart_serial_tx_if if2 ();

    uart_serial_tx #(.CLK_DIV(CLK_DIV), .STOP_BITS(1), .FIFO_DEPTH(FIFO_DEPTH)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_if      (if1),
        .err_clr_i  (errClr1),
        .uart_txd_o (txd1),
        .busy_o     (busy1),
        .ovf_err_o  (ovf1)
    );

    uart_serial_tx #(.CLK_DIV(CLK_DIV), .STOP_BITS(2), .FIFO_DEPTH(FIFO_DEPTH)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_if      (if2),
        .err_clr_i  (errClr2),
        .uart_txd_o (txd2),
        .busy_o     (busy2),
        .ovf_err_o  (ovf2)
    );

    // 10 ns system clock
    always #5 clk = ~clk;

    // Hard stop in case anything waits forever
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs on the selected instance; call at a negedge
    task automatic applyStimulus(input int sel, input logic en, input logic [7:0] d, input logic clr);
        if (sel == 0) begin
            if1.tx_en = en; if1.tx_data = d; errClr1 = clr;
        end else begin
            if2.tx_en = en; if2.tx_data = d; errClr2 = clr;
        end
        @(negedge clk);
        if (sel == 0) begin
            if1.tx_en = 1'b0; errClr1 = 1'b0;
        end else begin
            if2.tx_en = 1'b0; errClr2 = 1'b0;
        end
    endtask

    // One line sample per negedge, starting at the current negedge
    task automatic recordLine(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            rec[i] = (sel == 0) ? txd1 : txd2;
            @(negedge clk);
        end
        recLen = n;
    endtask

    task automatic waitIdle(input int sel, input int maxCycles);
        int n;
        n = 0;
        while (((sel == 0) ? busy1 : busy2) && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput($sformatf("wait idle dut%0d", sel + 1), (sel == 0) ? busy1 : busy2, 1'b0);
        @(negedge clk);
        @(negedge clk);
    endtask

    function automatic logic frameBit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Check nBytes contiguous frames of expBytes in rec, first start at startIdx
    task automatic checkFrames(input string name, input int startIdx, input int nBytes, input int stopBits);
        int fl;
        int s;
        int idx;
        fl = 9 + PAR_BITS + stopBits;
        s = -1;
        for (int i = 0; i < recLen; i++) begin
            if (s < 0 && rec[i] === 1'b0) s = i;
        end
        checkOutput({name, " start index"}, s, startIdx);
        if (s < 0) s = startIdx;
        for (int j = 0; j < nBytes; j++) begin
            for (int k = 0; k < fl; k++) begin
                for (int c = 0; c < CLK_DIV; c++) begin
                    idx = s + (j * fl + k) * CLK_DIV + c;
                    if (idx < recLen)
                        checkOutput($sformatf("%s byte%0d bit%0d", name, j, k), rec[idx], frameBit(expBytes[j], k));
                    else
                        checkOutput($sformatf("%s window", name), idx, recLen - 1);
                end
            end
        end
        idx = s + nBytes * fl * CLK_DIV;
        if (idx < recLen)
            checkOutput({name, " idle after"}, rec[idx], 1'b1);
        else
            checkOutput({name, " idle window"}, idx, recLen - 1);
    endtask

    vec_t vecs [8];
    logic lineExp [0:11];

    initial begin
        logic [7:0] burst [10];
        int sent;
        logic lastReady;
        int gap;

        if1.tx_en = 1'b0; if1.tx_data = 8'h00; errClr1 = 1'b0;
        if2.tx_en = 1'b0; if2.tx_data = 8'h00; errClr2 = 1'b0;

        // Single-frame vectors; expLine is the wire order start, d0..d7, stop
        vecs[0] = '{8'hEB, 10'b0_11010111_1, 1'b0};
        vecs[1] = '{8'h9C, 10'b0_00111001_1, 1'b0};
        vecs[2] = '{8'h07, 10'b0_11100000_1, 1'b1};
        vecs[3] = '{8'h03, 10'b0_11000000_1, 1'b0};
        vecs[4] = '{8'h55, 10'b0_10101010_1, 1'b0};
        vecs[5] = '{8'h00, 10'b0_00000000_1, 1'b0};
        vecs[6] = '{8'hFF, 10'b0_11111111_1, 1'b0};
        vecs[7] = '{8'h80, 10'b0_00000001_1, 1'b1};

        // Reset values while rst_n is held low
        #22;
        checkOutput("reset txd dut1",   txd1, 1'b1);
        checkOutput("reset busy dut1",  busy1, 1'b0);
        checkOutput("reset ready dut1", if1.tx_ready, 1'b1);
        checkOutput("reset ovf dut1",   ovf1, 1'b0);
        checkOutput("reset txd dut2",   txd2, 1'b1);
        checkOutput("reset busy dut2",  busy2, 1'b0);
        checkOutput("reset ready dut2", if2.tx_ready, 1'b1);
        checkOutput("reset ovf dut2",   ovf2, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven single frames with exact latency and bit timing
        $display("[TB] single-frame vectors");
        for (int i = 0; i < 8; i++) begin
            waitIdle(0, 200);
            for (int k = 0; k < 9; k++) lineExp[k] = vecs[i].expLine[9-k];
`ifdef UART_TX_PARITY_EN
            lineExp[9]  = vecs[i].expParity;
            lineExp[10] = vecs[i].expLine[0];
`else
            lineExp[9]  = vecs[i].expLine[0];
`endif
            applyStimulus(0, 1'b1, vecs[i].data, 1'b0);
            checkOutput($sformatf("vec%0d busy during", i), busy1, 1'b1);
            recordLine(0, 2 + FL1 * CLK_DIV + 1);
            checkOutput($sformatf("vec%0d busy after", i), busy1, 1'b0);
            checkOutput($sformatf("vec%0d latency edge1", i), rec[0], 1'b1);
            checkOutput($sformatf("vec%0d latency edge2", i), rec[1], 1'b1);
            for (int k = 0; k < FL1; k++) begin
                for (int c = 0; c < CLK_DIV; c++) begin
                    checkOutput($sformatf("vec%0d bit%0d cyc%0d", i, k, c), rec[2 + k * CLK_DIV + c], lineExp[k]);
                end
            end
            checkOutput($sformatf("vec%0d idle", i), rec[2 + FL1 * CLK_DIV], 1'b1);
        end

        // 10-byte burst paced by tx_ready with a one-cycle upstream latency
        $display("[TB] burst");
        waitIdle(0, 200);
        burst[0] = 8'hEB; burst[1] = 8'h9C;
        for (int i = 2; i < 10; i++) burst[i] = 8'(i - 1);
        for (int i = 0; i < 10; i++) expBytes[i] = burst[i];
        sent = 0;
        lastReady = if1.tx_ready;
        fork
            begin
                for (int cyc = 0; cyc < 460 && sent < 10; cyc++) begin
                    if (lastReady) begin
                        if1.tx_en = 1'b1;
                        if1.tx_data = burst[sent];
                        sent++;
                    end else begin
                        if1.tx_en = 1'b0;
                    end
                    lastReady = if1.tx_ready;
                    @(negedge clk);
                end
                if1.tx_en = 1'b0;
            end
            recordLine(0, 3 + 10 * FL1 * CLK_DIV + 2);
        join
        checkOutput("burst bytes sent", sent, 10);
        checkFrames("burst", 3, 10, 1);
        checkOutput("burst ovf", ovf1, 1'b0);

        // Six strobes into an idle block: one popped, four stored, one dropped
        $display("[TB] overflow");
        waitIdle(0, 200);
        for (int i = 0; i < 5; i++) expBytes[i] = 8'hA1 + 8'(i);
        fork
            begin
                for (int i = 0; i < 6; i++) applyStimulus(0, 1'b1, 8'hA1 + 8'(i), 1'b0);
                checkOutput("ovf set", ovf1, 1'b1);
                checkOutput("ovf ready low", if1.tx_ready, 1'b0);
                applyStimulus(0, 1'b0, 8'h00, 1'b1);
                checkOutput("ovf cleared", ovf1, 1'b0);
                applyStimulus(0, 1'b1, 8'hEE, 1'b1);
                checkOutput("ovf set wins", ovf1, 1'b1);
                applyStimulus(0, 1'b0, 8'h00, 1'b1);
                checkOutput("ovf cleared again", ovf1, 1'b0);
            end
            recordLine(0, 3 + 5 * FL1 * CLK_DIV + 4);
        join
        checkFrames("ovf", 3, 5, 1);

        // Reset in the middle of data bit 3, then an immediate write
        $display("[TB] reset mid-frame");
        waitIdle(0, 200);
        applyStimulus(0, 1'b1, 8'h07, 1'b0);
        repeat (19) @(negedge clk);
        checkOutput("midreset bit3 low", txd1, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset txd", txd1, 1'b1);
        checkOutput("midreset busy", busy1, 1'b0);
        checkOutput("midreset ready", if1.tx_ready, 1'b1);
        checkOutput("midreset ovf", ovf1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        expBytes[0] = 8'h55;
        applyStimulus(0, 1'b1, 8'h55, 1'b0);
        recordLine(0, 2 + FL1 * CLK_DIV + 2);
        checkFrames("post-reset", 2, 1, 1);

        // Two stop bits between queued frames
        $display("[TB] two stop bits");
        waitIdle(1, 200);
        expBytes[0] = 8'h9C;
        expBytes[1] = 8'h3A;
        fork
            begin
                applyStimulus(1, 1'b1, 8'h9C, 1'b0);
                applyStimulus(1, 1'b1, 8'h3A, 1'b0);
            end
            recordLine(1, 3 + 2 * FL2 * CLK_DIV + 2);
        join
        checkFrames("stop2", 3, 2, 2);
`ifndef UART_TX_PARITY_EN
        gap = 0;
        for (int i = 3 + 9 * CLK_DIV; i < recLen && rec[i] === 1'b1; i++) gap++;
        checkOutput("stop2 gap", gap, 2 * CLK_DIV);
`endif
        checkOutput("stop2 ovf", ovf2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/uart_serial_tx.md
UART_SERIAL_TX -- requirements
Module: uart_serial_tx

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 868: clk cycles per UART bit; legal values are 4 or more.
REQ-002 The block SHALL have parameter STOP_BITS, default 1: number of stop bits; legal values are 1 or 2.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4: byte FIFO entries; legal values are powers of two, 4 or more.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock, rising-edge active.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port tx_en, input, 1 bit: single-cycle byte write strobe from the frame builder.
REQ-007 The block SHALL have port tx_data, input, 8 bits: byte to send, sampled when tx_en=1.
REQ-008 The block SHALL have port err_clr, input, 1 bit: clears ovf_err.
REQ-009 The block SHALL have port tx_ready, output, 1 bit: at least 2 FIFO entries are free.
REQ-010 The block SHALL have port uart_txd, output, 1 bit: serial line, idle high, registered.
REQ-011 The block SHALL have port busy, output, 1 bit: the FSM is not IDLE or the FIFO is not empty.
REQ-012 The block SHALL have port ovf_err, output, 1 bit: sticky flag, set when a write was dropped.

Function
REQ-013 The byte FIFO SHALL accept tx_data on a clk edge with tx_en=1 and count<FIFO_DEPTH; when count=FIFO_DEPTH the byte SHALL be dropped.
REQ-014 tx_ready SHALL equal (count <= FIFO_DEPTH-2), decoded combinationally from the registered count; the 2-entry margin absorbs the upstream one-cycle ready-to-strobe latency.
REQ-015 A same-cycle write and pop SHALL leave count unchanged; this applies to a write at full only if the pop occurs first in priority, in which case the write is accepted.
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-017 In IDLE with the FIFO not empty, the FSM SHALL pop one byte into the shift register and go to START.
REQ-018 START SHALL drive 0; DATA SHALL drive bits 0..7, LSB first; PARITY SHALL drive the parity bit (REQ-029); STOP SHALL drive 1 for STOP_BITS bit periods.
REQ-019 Each bit SHALL last exactly CLK_DIV cycles, timed by a bit counter that resets at each bit boundary, plus a 3-bit index for DATA.
REQ-020 At the end of STOP, the FSM SHALL go to START if the FIFO is non-empty (popping the next byte), with no idle gap; otherwise it SHALL go to IDLE.
REQ-021 Latency: uart_txd SHALL fall at the second rising clk edge after the edge that sampled tx_en into an empty FIFO with the FSM in IDLE.
REQ-022 ovf_err SHALL set on a dropped write and clear on err_clr=1; if both occur in the same cycle, set SHALL win.
REQ-023 Bytes SHALL be transmitted in write order; FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-024 While rst_n=0, uart_txd SHALL be 1, the FSM SHALL be IDLE, and the FIFO SHALL be empty.
REQ-025 While rst_n=0, tx_ready SHALL be 1, busy SHALL be 0, ovf_err SHALL be 0, and all counters SHALL be 0.
REQ-026 Reset asserted mid-byte SHALL abort the frame immediately: uart_txd goes high with no stop bit completion, and FIFO contents are lost.
REQ-027 After reset deasserts, the block SHALL accept a write on the first clk edge.

Configuration
REQ-028 Macro UART_TX_PARITY_EN SHALL control the parity feature.
REQ-029 With UART_TX_PARITY_EN defined, the frame SHALL be start, 8 data bits, one even-parity bit (XOR of the 8 data bits), then stop.
REQ-030 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent, and the FSM SHALL go directly from DATA to STOP.

Verification
REQ-031 CLK_DIV=4, single write 0xEB: uart_txd SHALL carry 0,1,1,0,1,0,1,1,1,1, each bit 4 cycles, then 1 stop bit and a return to IDLE; busy SHALL fall once the stop bit ends.
REQ-032 10-byte burst EB,9C,01..08 using upstream ready/strobe timing: all 10 bytes SHALL be serialised in order, back-to-back with no gaps, and ovf_err SHALL stay 0.
REQ-033 FIFO_DEPTH=4, 6 consecutive tx_en strobes while the FSM is idle: 1 byte popped plus 4 stored SHALL be kept, the 6th byte SHALL be dropped, ovf_err SHALL be 1, and err_clr SHALL then clear it.
REQ-034 rst_n pulled low during data bit 3: uart_txd SHALL be 1 in the same cycle, busy SHALL be 0, and a new byte 0x55 written after release SHALL be sent correctly.
REQ-035 UART_TX_PARITY_EN defined, byte 0x07: the parity bit SHALL be 1; byte 0x03: the parity bit SHALL be 0.
REQ-036 STOP_BITS=2, two queued bytes: the gap between data bit 7 and the next start bit SHALL be exactly 2*CLK_DIV cycles of high.
